// File: rtl/write.sv
// spectrum_ram_writer: write-side controller for the HDMI spectrum display buffer.
// Takes the FFT magnitude stream and scales each bin to the display word width.
// It writes one frame out of every C_DECIM frames into the buffer, and a freeze
// request seen at a frame boundary makes it skip the next frame.
// Optional feature macro: SPECTRUM_SAT_EN (saturate instead of truncate when narrowing).
module write #(
    parameter int C_ADDR_WIDTH = 8,
    parameter int C_DATA_WIDTH = 8,
    parameter int C_IN_WIDTH   = 16,
    parameter int C_SHIFT      = 8,
    parameter int C_FRAME_LEN  = 512,
    parameter int C_DECIM      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [C_IN_WIDTH-1:0]   s_data,
    input  logic                    s_last,
    input  logic                    freeze,
    output logic                    wea,
    output logic [C_ADDR_WIDTH-1:0] addra,
    output logic [C_DATA_WIDTH-1:0] dina,
    output logic                    frame_done,
    output logic                    len_err
);

    localparam int IDX_W = $clog2(C_FRAME_LEN) + 1;
    localparam int CNT_W = (C_DECIM > 1) ? $clog2(C_DECIM) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(C_FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_PRE_SAT = {{(IDX_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(C_DECIM - 1);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_CAPTURE,
        ST_SKIP
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    rdy_q, rdy_d;
    logic                    wea_q, wea_d;
    logic [C_ADDR_WIDTH-1:0] addra_q, addra_d;
    logic [C_DATA_WIDTH-1:0] dina_q, dina_d;
    logic                    fd_q, fd_d;
    logic                    le_q, le_d;

    logic                    hs;
    logic                    hs_last;
    logic                    in_low;
    logic [C_DATA_WIDTH-1:0] x_scaled;

    // Handshake qualifiers, frame-counter successor and the lower-half bin test
    always_comb begin
        hs      = s_valid && rdy_q;
        hs_last = hs && s_last;
        cnt_inc = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        in_low  = (idx_q >> C_ADDR_WIDTH) == '0;
    end

    // Magnitude scaling: right shift, then narrow to the display word width
    always_comb begin
`ifdef SPECTRUM_SAT_EN
        x_scaled = ((s_data >> (C_SHIFT + C_DATA_WIDTH)) != '0) ? '1
                                                                : C_DATA_WIDTH'(s_data >> C_SHIFT);
`else
        x_scaled = C_DATA_WIDTH'(s_data >> C_SHIFT);
`endif
    end

    // State and frame-counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: decide capture/skip for the upcoming frame on every s_last handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hs_last) begin
            case (state_q)
                ST_SYNC: begin
                    // Leaving SYNC, the next frame counts as frame 0 of the decimation cycle
                    cnt_d   = '0;
                    state_d = freeze ? ST_SKIP : ST_CAPTURE;
                end
                default: begin
                    cnt_d   = cnt_inc;
                    state_d = ((cnt_inc == '0) && !freeze) ? ST_CAPTURE : ST_SKIP;
                end
            endcase
        end
    end

    // Outputs and beat index: write lower-half bins in CAPTURE and flag frame end and length errors
    always_comb begin
        rdy_d   = 1'b1;
        idx_d   = idx_q;
        wea_d   = 1'b0;
        addra_d = addra_q;
        dina_d  = dina_q;
        fd_d    = 1'b0;
        le_d    = 1'b0;
        if (hs) begin
            if (s_last) begin
                idx_d = '0;
            end else if (idx_q != '1) begin
                idx_d = idx_q + IDX_W'(1);
            end
            if ((state_q == ST_CAPTURE) && in_low) begin
                wea_d   = 1'b1;
                addra_d = idx_q[C_ADDR_WIDTH-1:0];
                dina_d  = x_scaled;
            end
            // The SYNC frame is a known fragment, so its length is not judged
            if (state_q != ST_SYNC) begin
                if (s_last) begin
                    le_d = (idx_q != IDX_LAST);
                    fd_d = (state_q == ST_CAPTURE);
                end else if (idx_q == IDX_PRE_SAT) begin
                    le_d = 1'b1;
                end
            end
        end
    end

    // Registered datapath and output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q   <= 1'b0;
            idx_q   <= '0;
            wea_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
            fd_q    <= 1'b0;
            le_q    <= 1'b0;
        end else begin
            rdy_q   <= rdy_d;
            idx_q   <= idx_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            fd_q    <= fd_d;
            le_q    <= le_d;
        end
    end

    // Port mapping
    always_comb begin
        s_ready    = rdy_q;
        wea        = wea_q;
        addra      = addra_q;
        dina       = dina_q;
        frame_done = fd_q;
        len_err    = le_q;
    end

endmodule
